axi_selftest_master: RTL and testbench

// - Meta-AXI4 master that self-tests a DDR-SDRAM controller over an address window of 2**A_WIDTH_TEST bytes.
// - It first fills the window with a known pattern, then loops forever issuing pseudo-random write and read bursts, checking every read beat.
// - It sits between the system clock domain (aclk) and the controller's AXI slave; error/error_cnt drive LEDs or a debug bus.

---
 rtl/axi_selftest_pkg.sv | 30 +++
 rtl/axi_selftest_lfsr32.sv | 29 ++
 rtl/axi_selftest_master.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_selftest_master.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_selftest_pkg.sv
// Shared types and helpers for the AXI self-test master.
//   state_e   : transaction sequencer states
//   LFSR_POLY : Galois feedback mask for x^32+x^22+x^2+x+1 (shift right)
//   pattern() : 16-bit word index replicated across the data bus
package axi_selftest_pkg;

  typedef enum logic [2:0] {
    INIT_AW,
    INIT_W,
    INIT_B,
    T_AW,
    T_W,
    T_B,
    T_AR,
    T_R
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam int unsigned PAT_MAX_W = 64;

  // Replicate the word index and zero everything above d_width (callers truncate).
  function automatic logic [PAT_MAX_W-1:0] pattern(input logic [15:0] w,
                                                   input int unsigned d_width);
    logic [PAT_MAX_W-1:0] r;
    r = {4{w}};
    if (d_width < PAT_MAX_W) r = r & ((PAT_MAX_W'(1) << d_width) - PAT_MAX_W'(1));
    return r;
  endfunction

endpackage

// File: rtl/axi_selftest_lfsr32.sv
// 32-bit Galois LFSR, shift right, seeded with 1 on reset.
//   aclk, areset : clock, synchronous active-high reset
//   en           : advance one step this cycle
//   q            : current LFSR state
module axi_selftest_lfsr32
  import axi_selftest_pkg::*;
(
  input  logic        aclk,
  input  logic        areset,
  input  logic        en,
  output logic [31:0] q
);

  logic [31:0] q_q, q_d;

  // Next state: shift right, fold in the polynomial when a one falls out.
  always_comb begin
    q_d = q_q;
    if (en) q_d = (q_q >> 1) ^ (q_q[0] ? LFSR_POLY : 32'h0);
  end

  always_ff @(posedge aclk) begin
    if (areset) q_q <= 32'h1;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/axi_selftest_master.sv
// AXI4 self-test master: fills a 2**A_WIDTH_TEST byte window with a
// word-index pattern, then alternates pseudo-random write and read bursts
// forever, checking every read beat.
//   aclk, areset          : clock, synchronous active-high reset
//   aw*/w*/b*             : write address / data / response channels
//   ar*/r*                : read address / data channels
//   error                 : one-cycle pulse per bad read beat
//   error_cnt             : saturating count of bad read beats
module axi_selftest_master
  import axi_selftest_pkg::*;
#(
  parameter int unsigned A_WIDTH_TEST = 12,
  parameter int unsigned A_WIDTH      = 26,
  parameter int unsigned D_WIDTH      = 16,
  parameter int unsigned D_LEVEL      = 1,
  parameter logic [7:0]  WBURST_LEN   = 8'd7,
  parameter logic [7:0]  RBURST_LEN   = 8'd7
) (
  input  logic               aclk,
  input  logic               areset,
  output logic               awvalid,
  input  logic               awready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [7:0]         awlen,
  output logic               wvalid,
  input  logic               wready,
  output logic               wlast,
  output logic [D_WIDTH-1:0] wdata,
  input  logic               bvalid,
  output logic               bready,
  output logic               arvalid,
  input  logic               arready,
  output logic [A_WIDTH-1:0] araddr,
  output logic [7:0]         arlen,
  input  logic               rvalid,
  output logic               rready,
  input  logic               rlast,
  input  logic [D_WIDTH-1:0] rdata,
  output logic               error,
  output logic [15:0]        error_cnt
);

  localparam int unsigned W_BYTES = (32'(WBURST_LEN) + 1) << D_LEVEL;
  localparam int unsigned R_BYTES = (32'(RBURST_LEN) + 1) << D_LEVEL;
  localparam int unsigned W_LSB   = $clog2(W_BYTES);
  localparam int unsigned R_LSB   = $clog2(R_BYTES);
  localparam int unsigned AE_W    = A_WIDTH + 1;
  localparam logic [AE_W-1:0] WIN_END = AE_W'(1) << A_WIDTH_TEST;

  state_e               state_q, state_d;
  logic                 awvalid_q, awvalid_d;
  logic [A_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic                 wvalid_q, wvalid_d;
  logic                 wlast_q, wlast_d;
  logic [D_WIDTH-1:0]   wdata_q, wdata_d;
  logic                 bready_q, bready_d;
  logic                 arvalid_q, arvalid_d;
  logic [A_WIDTH-1:0]   araddr_q, araddr_d;
  logic                 rready_q, rready_d;
  logic                 error_q, error_d;
  logic [15:0]          error_cnt_q, error_cnt_d;
  logic [7:0]           beat_q, beat_d;

  logic                 lfsr_en_c;
  logic [31:0]          lfsr_q;
  logic [A_WIDTH-1:0]   wr_taddr_c, rd_taddr_c;
  logic                 sweep_last_c;
  logic                 rd_bad_c;
  logic [7:0]           beat_nxt_c;
  logic                 unused_lfsr_hi;

  axi_selftest_lfsr32 u_lfsr (
    .aclk   (aclk),
    .areset (areset),
    .en     (lfsr_en_c),
    .q      (lfsr_q)
  );

  // Expected bus word for beat 'beat' of a burst starting at byte 'base'.
  function automatic logic [D_WIDTH-1:0] beat_pat(input logic [A_WIDTH-1:0] base,
                                                  input logic [7:0] beat);
    return D_WIDTH'(pattern(16'((base >> D_LEVEL) + A_WIDTH'(beat)), D_WIDTH));
  endfunction

  // Burst-aligned random addresses inside the window, so bursts never cross its end.
  assign wr_taddr_c = A_WIDTH'((lfsr_q[A_WIDTH_TEST-1:0] >> W_LSB) << W_LSB);
  assign rd_taddr_c = A_WIDTH'((lfsr_q[A_WIDTH_TEST-1:0] >> R_LSB) << R_LSB);
  assign unused_lfsr_hi = ^lfsr_q[31:A_WIDTH_TEST];

  assign sweep_last_c = (AE_W'(awaddr_q) + AE_W'(W_BYTES)) == WIN_END;
  assign beat_nxt_c   = beat_q + 8'd1;
  assign rd_bad_c     = (rdata != beat_pat(araddr_q, beat_q)) ||
                        (rlast != (beat_q == RBURST_LEN));

  // Sequencer: next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    awaddr_d    = awaddr_q;
    wvalid_d    = wvalid_q;
    wlast_d     = wlast_q;
    wdata_d     = wdata_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    rready_d    = rready_q;
    error_d     = 1'b0;
    error_cnt_d = error_cnt_q;
    beat_d      = beat_q;
    lfsr_en_c   = 1'b0;

    case (state_q)
      INIT_AW, T_AW: begin
        awvalid_d = 1'b1;
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          lfsr_en_c = 1'b1;
          state_d   = (state_q == INIT_AW) ? INIT_W : T_W;
          wvalid_d  = 1'b1;
          beat_d    = 8'd0;
          wdata_d   = beat_pat(awaddr_q, 8'd0);
          wlast_d   = (WBURST_LEN == 8'd0);
        end
      end
      INIT_W, T_W: begin
        if (wvalid_q && wready) begin
          if (beat_q == WBURST_LEN) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = (state_q == INIT_W) ? INIT_B : T_B;
          end else begin
            beat_d  = beat_nxt_c;
            wdata_d = beat_pat(awaddr_q, beat_nxt_c);
            wlast_d = (beat_nxt_c == WBURST_LEN);
          end
        end
      end
      INIT_B: begin
        if (bready_q && bvalid) begin
          bready_d = 1'b0;
          if (sweep_last_c) begin
            state_d  = T_AW;
            awaddr_d = wr_taddr_c;
          end else begin
            state_d  = INIT_AW;
            awaddr_d = awaddr_q + A_WIDTH'(W_BYTES);
          end
        end
      end
      T_B: begin
        if (bready_q && bvalid) begin
          bready_d = 1'b0;
          state_d  = T_AR;
          araddr_d = rd_taddr_c;
        end
      end
      T_AR: begin
        arvalid_d = 1'b1;
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          lfsr_en_c = 1'b1;
          rready_d  = 1'b1;
          beat_d    = 8'd0;
          state_d   = T_R;
        end
      end
      T_R: begin
        if (rready_q && rvalid) begin
          if (rd_bad_c) begin
            error_d = 1'b1;
            if (error_cnt_q != 16'hFFFF) error_cnt_d = error_cnt_q + 16'd1;
          end
          // Burst length is counted locally; a missing rlast cannot stall the loop.
          if (beat_q == RBURST_LEN) begin
            rready_d = 1'b0;
            state_d  = T_AW;
            awaddr_d = wr_taddr_c;
          end else begin
            beat_d = beat_nxt_c;
          end
        end
      end
      default: state_d = INIT_AW;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= INIT_AW;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      wdata_q     <= '0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      error_q     <= 1'b0;
      error_cnt_q <= 16'd0;
      beat_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      awaddr_q    <= awaddr_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      wdata_q     <= wdata_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      rready_q    <= rready_d;
      error_q     <= error_d;
      error_cnt_q <= error_cnt_d;
      beat_q      <= beat_d;
    end
  end

  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign awlen     = WBURST_LEN;
  assign wvalid    = wvalid_q;
  assign wlast     = wlast_q;
  assign wdata     = wdata_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arlen     = RBURST_LEN;
  assign rready    = rready_q;
  assign error     = error_q;
  assign error_cnt = error_cnt_q;

endmodule

// File: tb/tb_axi_selftest_master.sv
// Bench for axi_selftest_master: slave + transaction-level reference model,
// directed table of the first write beats, and randomized handshake phases.
module tb_axi_selftest_master;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready, error;
  logic [25:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [15:0] wdata, error_cnt;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [15:0] rdata = 16'h0;

  always #5 aclk = ~aclk;

  axi_selftest_master dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
    .error(error), .error_cnt(error_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules: LFSR step, burst-aligned window address, pattern word.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction
  function automatic logic [31:0] win_addr(input logic [31:0] l);
    return ((l % 32'h1000) / 32'd16) * 32'd16;
  endfunction

  // ---------------- slave + reference model ----------------
  localparam int P_AW = 0, P_W = 1, P_B = 2, P_AR = 3, P_R = 4;
  typedef struct { logic [15:0] data; logic last; bit bad; } rbeat_t;
  typedef struct { logic [15:0] data; logic last; } wbeat_t;

  int          phase, init_cnt, beat, w_total, rd_bursts, err_cnt_m;
  bit          init_done, cur_init, b_pend, err_exp;
  logic [31:0] lfsr_m, cur_waddr, max_araddr;
  logic [15:0] mem [0:2047];
  rbeat_t      rq[$];
  logic [31:0] aw_log[$];
  wbeat_t      w_log[$];
  bit          rdy_rand = 0, spurious = 0;
  int          stall_at = -1, stall_len = 0, stall_cnt = 0, stall_seen = 0;
  bit          stall_done;
  int          corrupt_burst = -1;
  int          err_high = 0, err_rise = 0;
  bit          err_prev;
  bit          aw_hold, w_hold, ar_hold;
  logic [25:0] aw_hold_addr, ar_hold_addr;
  logic [15:0] w_hold_data;
  logic        w_hold_last;

  function automatic bit coin();
    return rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        phase = P_AW; init_cnt = 0; init_done = 0; lfsr_m = 32'h1; beat = 0;
        b_pend = 0; rq.delete(); err_cnt_m = 0; err_exp = 0; err_prev = 0;
        aw_log.delete(); w_log.delete(); w_total = 0; rd_bursts = 0;
        stall_done = 0; stall_cnt = 0; aw_hold = 0; w_hold = 0; ar_hold = 0;
        max_araddr = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
        continue;
      end
      // per-cycle output checks against the model
      check("error", 32'(error), 32'(err_exp));
      check("error_cnt", 32'(error_cnt), 32'(err_cnt_m));
      if (error) err_high++;
      if (error && !err_prev) err_rise++;
      err_prev = error;
      err_exp = 0;
      if (phase != P_AW) check("awvalid_idle", 32'(awvalid), 0);
      if (phase != P_AR) check("arvalid_idle", 32'(arvalid), 0);
      if (phase == P_W) check("wvalid_held", 32'(wvalid), 1);
      else begin check("wvalid_idle", 32'(wvalid), 0); check("wlast_idle", 32'(wlast), 0); end
      if (phase == P_B) check("bready", 32'(bready), 1); else check("bready_idle", 32'(bready), 0);
      if (phase == P_R) check("rready", 32'(rready), 1); else check("rready_idle", 32'(rready), 0);
      if (aw_hold) begin
        check("aw_hold_valid", 32'(awvalid), 1); check("aw_hold_addr", 32'(awaddr), 32'(aw_hold_addr));
      end
      if (ar_hold) begin
        check("ar_hold_valid", 32'(arvalid), 1); check("ar_hold_addr", 32'(araddr), 32'(ar_hold_addr));
      end
      if (w_hold) begin
        check("w_hold_data", 32'(wdata), 32'(w_hold_data)); check("w_hold_last", 32'(wlast), 32'(w_hold_last));
      end

      // slave drives its inputs for the coming edge
      awready = coin();
      arready = coin();
      if (phase == P_W && w_total == stall_at && !stall_done) begin
        stall_done = 1; stall_cnt = stall_len;
      end
      if (stall_cnt > 0) begin
        wready = 0; stall_cnt--;
        if (wvalid) stall_seen++;
      end else wready = coin();
      bvalid = b_pend ? coin() : (spurious && $urandom_range(0, 7) == 0);
      if (rq.size() > 0) begin
        rvalid = coin(); rdata = rq[0].data; rlast = rq[0].last;
      end else begin
        rvalid = spurious && $urandom_range(0, 7) == 0;
        rdata = 16'($urandom); rlast = 1'($urandom);
      end

      // handshakes happening on the coming edge
      aw_hold = awvalid && !awready; aw_hold_addr = awaddr;
      ar_hold = arvalid && !arready; ar_hold_addr = araddr;
      w_hold  = wvalid && !wready;   w_hold_data = wdata; w_hold_last = wlast;

      if (awvalid && awready) begin
        cur_waddr = init_done ? win_addr(lfsr_m) : 32'(init_cnt) * 32'd16;
        check("awaddr", 32'(awaddr), cur_waddr);
        check("awlen", 32'(awlen), 7);
        cur_init = !init_done;
        if (!init_done) init_cnt++;
        if (aw_log.size() < 600) aw_log.push_back(32'(awaddr));
        lfsr_m = lfsr_step(lfsr_m);
        phase = P_W; beat = 0;
      end
      if (wvalid && wready) begin
        check("wdata", 32'(wdata), (cur_waddr / 2 + 32'(beat)) & 32'hFFFF);
        check("wlast", 32'(wlast), 32'(beat == 7));
        mem[(cur_waddr / 2 + 32'(beat)) % 2048] = wdata;
        if (w_log.size() < 4096) w_log.push_back('{wdata, wlast});
        w_total++;
        if (beat == 7) begin phase = P_B; b_pend = 1; end
        else beat++;
      end
      if (bvalid && bready) begin
        if (!b_pend) begin
          n_tests++; n_fail++;
          $display("FAIL b_spurious: response accepted with no write outstanding (t=%0t)", $time);
        end else begin
          b_pend = 0;
          if (cur_init) begin
            phase = P_AW;
            if (init_cnt == 256) init_done = 1;
          end else phase = P_AR;
        end
      end
      if (arvalid && arready) begin
        logic [31:0] ra;
        ra = win_addr(lfsr_m);
        check("araddr", 32'(araddr), ra);
        check("arlen", 32'(arlen), 7);
        if (32'(araddr) > max_araddr) max_araddr = 32'(araddr);
        lfsr_m = lfsr_step(lfsr_m);
        for (int b = 0; b < 8; b++) begin
          rbeat_t rb;
          rb.data = mem[(ra / 2 + 32'(b)) % 2048];
          rb.last = (b == 7);
          rb.bad  = (rd_bursts == corrupt_burst) && (b == 3);
          if (rb.bad) rb.data = rb.data ^ 16'h1;
          rq.push_back(rb);
        end
        rd_bursts++;
        phase = P_R;
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r_spurious: read beat accepted with no read outstanding (t=%0t)", $time);
        end else begin
          rbeat_t rb;
          rb = rq.pop_front();
          if (rb.bad) begin
            err_exp = 1;
            if (err_cnt_m < 65535) err_cnt_m++;
          end
          if (rb.last) phase = P_AW;
        end
      end
      if (n_fail >= 200) begin
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  // ---------------- directed sequences ----------------
  task automatic sample();
    @(posedge aclk); #2;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_awvalid"}, 32'(awvalid), 0);
    check({tag, "_wvalid"}, 32'(wvalid), 0);
    check({tag, "_wlast"}, 32'(wlast), 0);
    check({tag, "_bready"}, 32'(bready), 0);
    check({tag, "_arvalid"}, 32'(arvalid), 0);
    check({tag, "_rready"}, 32'(rready), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_awaddr"}, 32'(awaddr), 0);
    check({tag, "_araddr"}, 32'(araddr), 0);
    check({tag, "_error_cnt"}, 32'(error_cnt), 0);
    check({tag, "_awlen"}, 32'(awlen), 7);
    check({tag, "_arlen"}, 32'(arlen), 7);
  endtask

  task automatic wait_w(input int n, input int budget, input string name);
    int c = 0;
    while (w_total < n && c < budget) begin @(posedge aclk); c++; end
    check(name, 32'(w_total >= n), 1);
  endtask

  typedef struct { logic [31:0] awaddr; logic [15:0] wdata; logic wlast; } vec_t;
  vec_t tbl [16];

  initial begin
    logic [31:0] l;
    int c;
    for (int i = 0; i < 16; i++)
      tbl[i] = '{awaddr: 32'((i / 8) * 16), wdata: 16'(i), wlast: (i % 8) == 7};

    // reset state, then the first two init bursts with a 5-cycle wready stall
    stall_at = 11; stall_len = 5;
    repeat (3) sample();
    check_reset("rst");
    areset = 1'b0;
    wait_w(16, 2000, "first_bursts_timeout");
    for (int i = 0; i < 16; i++) begin
      if (i < w_log.size()) begin
        check("tbl_wdata", 32'(w_log[i].data), 32'(tbl[i].wdata));
        check("tbl_wlast", 32'(w_log[i].last), 32'(tbl[i].wlast));
      end
      if (i / 8 < aw_log.size()) check("tbl_awaddr", aw_log[i / 8], tbl[i].awaddr);
    end
    check("stall_cycles", 32'(stall_seen), 5);

    // init sweep completion and first random write address
    c = 0;
    while (aw_log.size() < 257 && c < 20000) begin sample(); c++; end
    check("sweep_timeout", 32'(aw_log.size() >= 257), 1);
    if (aw_log.size() >= 257) begin
      l = 32'h1;
      repeat (256) l = lfsr_step(l);
      check("sweep_last_awaddr", aw_log[255], 32'hFF0);
      for (int k = 0; k < 8; k++) check("sweep_last_wdata", 32'(w_log[2040 + k].data), 32'h7F8 + 32'(k));
      check("first_test_awaddr", aw_log[256], win_addr(l));
      check("first_test_awaddr_lsb", aw_log[256] & 32'hF, 0);
    end

    // long randomized run with a correct memory: no errors, addresses inside the window
    rdy_rand = 1; spurious = 1; err_high = 0;
    repeat (30000) sample();
    check("rand_err_cycles", 32'(err_high), 0);
    check("rand_error_cnt", 32'(error_cnt), 0);
    check("rand_araddr_in_window", 32'(max_araddr < 32'h1000), 1);
    check("rand_reads_done", 32'(rd_bursts > 100), 1);

    // one corrupted read beat
    err_rise = 0; err_high = 0;
    corrupt_burst = rd_bursts + 1;
    c = 0;
    while (rd_bursts < corrupt_burst + 4 && c < 5000) begin sample(); c++; end
    check("corrupt_timeout", 32'(rd_bursts >= corrupt_burst + 4), 1);
    check("corrupt_err_pulses", 32'(err_rise), 1);
    check("corrupt_err_cycles", 32'(err_high), 1);
    check("corrupt_error_cnt", 32'(error_cnt), 1);
    corrupt_burst = -1;

    // reset at beat 4 of the first init burst
    rdy_rand = 0; spurious = 0; stall_at = -1;
    areset = 1'b1;
    repeat (2) sample();
    areset = 1'b0;
    c = 0;
    while (w_total < 4 && c < 100) begin @(posedge aclk); c++; end
    check("midburst_reach", 32'(w_total), 4);
    #2 areset = 1'b1;
    sample();
    check_reset("midrst");
    areset = 1'b0;
    wait_w(8, 200, "post_reset_timeout");
    if (aw_log.size() > 0) check("post_reset_awaddr", aw_log[0], 0);
    for (int k = 0; k < 8 && k < w_log.size(); k++)
      check("post_reset_wdata", 32'(w_log[k].data), 32'(k));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
